// File: rtl/spatz_vcsr_issue.sv
// spatz_vcsr_issue: buffers vsetvl/vector-CSR instructions and turns them into CSR block updates.
// Define SPATZ_VCSR_ISSUE_BYPASS_EN to answer a CSRR at the FIFO head in the same cycle.
module spatz_vcsr_issue #(
    parameter int unsigned VLEN  = 512,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VL_W  = $clog2(VLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [1:0]      req_csr_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [7:0]      req_vtype_i,
    input  logic            req_keep_vl_i,
    input  logic [4:0]      req_rd_i,
    input  logic            vec_busy_i,
    input  logic            flush_i,
    output logic            vcsr_valid_o,
    output logic [2:0]      vcsr_op_o,
    output logic [XLEN-1:0] vcsr_rs1_o,
    output logic [7:0]      vcsr_vtype_o,
    output logic            vcsr_keep_vl_o,
    input  logic [VL_W-1:0] vl_i,
    input  logic [VL_W-1:0] vstart_i,
    input  logic [7:0]      vtype_i,
    input  logic            vill_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [4:0]      rsp_rd_o,
    output logic            rsp_vill_o
);

    localparam logic [2:0] OP_VSETVL = 3'd0;
    localparam logic [2:0] OP_CSRS   = 3'd2;
    localparam logic [2:0] OP_CSRR   = 3'd4;
    localparam logic [1:0] CSR_VSTART = 2'd0;
    localparam logic [1:0] CSR_VL     = 2'd1;
    localparam logic [1:0] CSR_VTYPE  = 2'd2;
    localparam logic [1:0] CSR_VLENB  = 2'd3;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [2:0]      op;
        logic [1:0]      csr;
        logic [XLEN-1:0] rs1;
        logic [7:0]      vtype;
        logic            keep_vl;
        logic [4:0]      rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_e          state_q;
    logic [XLEN-1:0] hold_q, rsp_data_q, vcsr_rs1_q;
    logic [4:0]      rsp_rd_q;
    logic            rsp_valid_q, rsp_vill_q;
    logic            vcsr_valid_q, vcsr_keep_vl_q;
    logic [2:0]      vcsr_op_q;
    logic [7:0]      vcsr_vtype_q;

    entry_t          head;
    logic [XLEN-1:0] old_val;
    logic            full, empty, push, pop, start;
    logic            is_csrr, is_vset, ro_skip, byp_csrr, byp_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign head    = mem_q[rd_ptr_q];
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign is_csrr = head.op == OP_CSRR;
    assign is_vset = head.op == OP_VSETVL;
    // vl and vlenb cannot be written by CSR instructions
    assign ro_skip = !is_vset && (head.csr == CSR_VL || head.csr == CSR_VLENB);

`ifdef SPATZ_VCSR_ISSUE_BYPASS_EN
    assign byp_csrr = is_csrr;
`else
    assign byp_csrr = 1'b0;
`endif

    assign byp_valid = byp_csrr && state_q == IDLE && !empty && !flush_i;
    assign start = state_q == IDLE && !empty && !vec_busy_i
                   && !flush_i && !byp_csrr;
    assign push  = req_valid_i && !full && !flush_i;
    assign pop   = rsp_ready_i && !flush_i && (rsp_valid_q || byp_valid);

    always_comb begin
        old_val = '0;
        unique case (head.csr)
            CSR_VSTART: old_val = XLEN'(vstart_i);
            CSR_VL:     old_val = XLEN'(vl_i);
            CSR_VTYPE:  old_val = XLEN'({vill_i, vtype_i});
            default:    old_val = XLEN'(VLEN / 8);
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            // an entry already sent to the CSR block must still be answered
            if (state_q == ISSUE || state_q == WAIT) begin
                wr_ptr_d = ptr_inc(rd_ptr_q);
                cnt_d    = CW'(1);
            end else begin
                wr_ptr_d = rd_ptr_q;
                cnt_d    = '0;
            end
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{req_op_i, req_csr_i, req_rs1_i,
                                 req_vtype_i, req_keep_vl_i, req_rd_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_rd_q       <= '0;
            rsp_vill_q     <= 1'b0;
            vcsr_valid_q   <= 1'b0;
            vcsr_op_q      <= '0;
            vcsr_rs1_q     <= '0;
            vcsr_vtype_q   <= '0;
            vcsr_keep_vl_q <= 1'b0;
        end else begin
            vcsr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && ro_skip) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= old_val;
                        rsp_vill_q  <= 1'b0;
                        rsp_rd_q    <= head.rd;
                    end else if (start) begin
                        state_q        <= ISSUE;
                        vcsr_valid_q   <= 1'b1;
                        vcsr_op_q      <= is_csrr ? OP_CSRS : head.op;
                        vcsr_rs1_q     <= is_csrr ? '0 : head.rs1;
                        vcsr_vtype_q   <= head.vtype;
                        vcsr_keep_vl_q <= head.keep_vl;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    hold_q  <= old_val;
                end
                WAIT: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= is_vset ? XLEN'(vl_i) : hold_q;
                    rsp_vill_q  <= is_vset && vill_i;
                    rsp_rd_q    <= head.rd;
                end
                RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o    = !full;
    assign vcsr_valid_o   = vcsr_valid_q;
    assign vcsr_op_o      = vcsr_op_q;
    assign vcsr_rs1_o     = vcsr_rs1_q;
    assign vcsr_vtype_o   = vcsr_vtype_q;
    assign vcsr_keep_vl_o = vcsr_keep_vl_q;
    assign rsp_valid_o    = rsp_valid_q || byp_valid;
    assign rsp_data_o     = byp_valid ? old_val : rsp_data_q;
    assign rsp_rd_o       = byp_valid ? head.rd : rsp_rd_q;
    assign rsp_vill_o     = !byp_valid && rsp_vill_q;

endmodule

// File: tb/tb_spatz_vcsr_issue.sv
// tb_spatz_vcsr_issue: vector table plus scoreboard against a behavioural CSR block.
// Follows SPATZ_VCSR_ISSUE_BYPASS_EN for the CSRR latency/pulse expectations.
`timescale 1ns/1ps
module tb_spatz_vcsr_issue;

    localparam int VLEN  = 512;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int VL_W  = $clog2(VLEN) + 1;
`ifdef SPATZ_VCSR_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [2:0]      req_op_i = '0;
    logic [1:0]      req_csr_i = '0;
    logic [XLEN-1:0] req_rs1_i = '0;
    logic [7:0]      req_vtype_i = '0;
    logic            req_keep_vl_i = 1'b0;
    logic [4:0]      req_rd_i = '0;
    logic            vec_busy_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            vcsr_valid_o;
    logic [2:0]      vcsr_op_o;
    logic [XLEN-1:0] vcsr_rs1_o;
    logic [7:0]      vcsr_vtype_o;
    logic            vcsr_keep_vl_o;
    logic [VL_W-1:0] m_vl, m_vstart;
    logic [7:0]      m_vtype;
    logic            m_vill;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b1;
    logic [XLEN-1:0] rsp_data_o;
    logic [4:0]      rsp_rd_o;
    logic            rsp_vill_o;

    spatz_vcsr_issue #(.VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_csr_i(req_csr_i), .req_rs1_i(req_rs1_i),
        .req_vtype_i(req_vtype_i), .req_keep_vl_i(req_keep_vl_i),
        .req_rd_i(req_rd_i), .vec_busy_i(vec_busy_i), .flush_i(flush_i),
        .vcsr_valid_o(vcsr_valid_o), .vcsr_op_o(vcsr_op_o),
        .vcsr_rs1_o(vcsr_rs1_o), .vcsr_vtype_o(vcsr_vtype_o),
        .vcsr_keep_vl_o(vcsr_keep_vl_o),
        .vl_i(m_vl), .vstart_i(m_vstart), .vtype_i(m_vtype), .vill_i(m_vill),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .rsp_vill_o(rsp_vill_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int vlmax_of(input logic [7:0] vt);
        int v;
        v = VLEN / (8 << vt[5:3]);
        if (vt[2:0] < 3'd4) v = v << vt[2:0];
        else v = v >> (8 - int'(vt[2:0]));
        return v;
    endfunction

    // Behavioural vector CSR block; CSR ops always target vstart here
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_vl <= '0; m_vstart <= '0; m_vtype <= '0; m_vill <= 1'b0;
        end else if (vcsr_valid_o) begin
            case (vcsr_op_o)
                3'd0: begin
                    if (vcsr_vtype_o[5:3] > 3'd2 || vcsr_vtype_o[2:0] == 3'd4) begin
                        m_vill <= 1'b1; m_vtype <= '0; m_vl <= '0;
                    end else begin
                        m_vill  <= 1'b0;
                        m_vtype <= vcsr_vtype_o;
                        if (!vcsr_keep_vl_o)
                            m_vl <= VL_W'((int'(vcsr_rs1_o) < vlmax_of(vcsr_vtype_o))
                                    ? int'(vcsr_rs1_o) : vlmax_of(vcsr_vtype_o));
                    end
                end
                3'd1: m_vstart <= VL_W'(vcsr_rs1_o);
                3'd2: m_vstart <= m_vstart | VL_W'(vcsr_rs1_o);
                3'd3: m_vstart <= m_vstart & ~VL_W'(vcsr_rs1_o);
                default: ;
            endcase
        end
    end

    int          pulses = 0;
    logic [2:0]  last_op = '0;
    logic [31:0] last_rs1 = '0;
    always @(negedge clk_i) begin
        if (vcsr_valid_o) begin
            pulses   <= pulses + 1;
            last_op  <= vcsr_op_o;
            last_rs1 <= vcsr_rs1_o;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        vill;
        logic [4:0]  rd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  csr;
        logic [31:0] rs1;
        logic [7:0]  vt;
        logic        kv;
        logic [4:0]  rd;
        logic [31:0] ed;
        logic        ev;
        int          ep;
        int          el;
    } vec_t;
    vec_t tbl[16];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [1:0] csr,
                        input logic [31:0] rs1, input logic [7:0] vt,
                        input logic kv, input logic [4:0] rd);
        req_valid_i = 1'b1; req_op_i = op; req_csr_i = csr; req_rs1_i = rs1;
        req_vtype_i = vt; req_keep_vl_i = kv; req_rd_i = rd;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic collect(input string nm, output int lat);
        exp_t e;
        lat = 0;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!rsp_valid_o) begin
            total++; bad++;
            $display("FAIL %s: got no response want response", nm);
        end else if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got response want none", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_data"}, rsp_data_o, e.data);
            chk({nm, "_vill"}, 32'(rsp_vill_o), 32'(e.vill));
            chk({nm, "_rd"}, 32'(rsp_rd_o), 32'(e.rd));
            @(posedge clk_i); #1;
        end
    endtask

    task automatic quiet(input string nm, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p0;
        tbl[0]  = '{3'd0, 2'd0, 32'd100,  8'h10, 1'b0, 5'd1,  32'd16,   1'b0, 1, 3};
        tbl[1]  = '{3'd1, 2'd0, 32'd3,    8'h00, 1'b0, 5'd2,  32'd0,    1'b0, 1, 3};
        tbl[2]  = '{3'd1, 2'd0, 32'd5,    8'h00, 1'b0, 5'd3,  32'd3,    1'b0, 1, 3};
        tbl[3]  = '{3'd2, 2'd0, 32'hA,    8'h00, 1'b0, 5'd4,  32'd5,    1'b0, 1, 3};
        tbl[4]  = '{3'd3, 2'd0, 32'd3,    8'h00, 1'b0, 5'd5,  32'd15,   1'b0, 1, 3};
        tbl[5]  = '{3'd4, 2'd0, 32'd0,    8'h00, 1'b0, 5'd6,  32'd12,   1'b0, 1, 3};
        tbl[6]  = '{3'd4, 2'd3, 32'd0,    8'h00, 1'b0, 5'd7,  32'd64,   1'b0, 0, 1};
        tbl[7]  = '{3'd4, 2'd1, 32'd0,    8'h00, 1'b0, 5'd8,  32'd16,   1'b0, 0, 1};
        tbl[8]  = '{3'd4, 2'd2, 32'd0,    8'h00, 1'b0, 5'd9,  32'h10,   1'b0, 1, 3};
        tbl[9]  = '{3'd1, 2'd1, 32'd77,   8'h00, 1'b0, 5'd10, 32'd16,   1'b0, 0, 1};
        tbl[10] = '{3'd0, 2'd0, 32'd0,    8'h11, 1'b1, 5'd11, 32'd16,   1'b0, 1, 3};
        tbl[11] = '{3'd0, 2'd0, 32'd1000, 8'h03, 1'b0, 5'd12, 32'd512,  1'b0, 1, 3};
        tbl[12] = '{3'd0, 2'd0, 32'd10,   8'h18, 1'b0, 5'd13, 32'd0,    1'b1, 1, 3};
        tbl[13] = '{3'd4, 2'd2, 32'd0,    8'h00, 1'b0, 5'd14, 32'h100,  1'b0, 1, 3};
        tbl[14] = '{3'd0, 2'd0, 32'd7,    8'hD1, 1'b0, 5'd15, 32'd7,    1'b0, 1, 3};
        tbl[15] = '{3'd4, 2'd1, 32'd0,    8'h00, 1'b0, 5'd16, 32'd7,    1'b0, 0, 1};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_flags", {28'd0, vcsr_valid_o, rsp_valid_o, rsp_vill_o, vcsr_keep_vl_o}, 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_vrs1", vcsr_rs1_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 16; i++) begin
            vec_t v;
            int ep, el;
            v  = tbl[i];
            ep = (BYP && v.op == 3'd4) ? 0 : v.ep;
            el = (BYP && v.op == 3'd4) ? 0 : v.el;
            p0 = pulses;
            sbq.push_back(exp_t'{v.ed, v.ev, v.rd});
            push(v.op, v.csr, v.rs1, v.vt, v.kv, v.rd);
            collect($sformatf("v%0d", i), lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(el));
            chk($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'(ep));
            if (ep != 0) begin
                chk($sformatf("v%0d_vop", i), 32'(last_op),
                    (v.op == 3'd4) ? 32'd2 : 32'(v.op));
                chk($sformatf("v%0d_vrs1", i), last_rs1,
                    (v.op == 3'd4) ? 32'd0 : v.rs1);
            end
        end

        // two queued requests held back by vec_busy_i
        vec_busy_i = 1'b1;
        p0 = pulses;
        sbq.push_back(exp_t'{32'd12, 1'b0, 5'd17});
        push(3'd1, 2'd0, 32'd20, 8'h00, 1'b0, 5'd17);
        sbq.push_back(exp_t'{32'd20, 1'b0, 5'd18});
        push(3'd2, 2'd0, 32'd1, 8'h00, 1'b0, 5'd18);
        chk("busy_full", 32'(req_ready_o), 32'd0);
        quiet("busy_no_rsp", 10);
        chk("busy_no_pulse", 32'(pulses - p0), 32'd0);
        chk("busy_still_full", 32'(req_ready_o), 32'd0);
        vec_busy_i = 1'b0;
        collect("busy_r0", lat);
        collect("busy_r1", lat);
        chk("busy_pulses", 32'(pulses - p0), 32'd2);

        // flush while WAIT with one entry queued behind
        p0 = pulses;
        sbq.push_back(exp_t'{32'd21, 1'b0, 5'd19});
        push(3'd1, 2'd0, 32'd30, 8'h00, 1'b0, 5'd19);
        push(3'd1, 2'd0, 32'd40, 8'h00, 1'b0, 5'd20);
        chk("fw_issue", 32'(vcsr_valid_o), 32'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        collect("fw_rsp", lat);
        chk("fw_empty", 32'(req_ready_o), 32'd1);
        quiet("fw_no_extra", 8);
        chk("fw_pulses", 32'(pulses - p0), 32'd1);
        sbq.push_back(exp_t'{32'd30, 1'b0, 5'd21});
        push(3'd4, 2'd0, 32'd0, 8'h00, 1'b0, 5'd21);
        collect("fw_check", lat);

        // flush while a response is stalled
        rsp_ready_i = 1'b0;
        push(3'd1, 2'd0, 32'd50, 8'h00, 1'b0, 5'd22);
        lat = 0;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk("fr_valid", 32'(rsp_valid_o), 32'd1);
        chk("fr_data", rsp_data_o, 32'd30);
        repeat (2) @(posedge clk_i);
        #1;
        chk("fr_hold_valid", 32'(rsp_valid_o), 32'd1);
        chk("fr_hold_data", rsp_data_o, 32'd30);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("fr_dropped", 32'(rsp_valid_o), 32'd0);
        rsp_ready_i = 1'b1;
        quiet("fr_quiet", 5);
        sbq.push_back(exp_t'{32'd50, 1'b0, 5'd23});
        push(3'd4, 2'd0, 32'd0, 8'h00, 1'b0, 5'd23);
        collect("fr_check", lat);

        // a push coinciding with flush is discarded
        flush_i = 1'b1;
        push(3'd1, 2'd0, 32'd99, 8'h00, 1'b0, 5'd24);
        flush_i = 1'b0;
        quiet("pf_quiet", 6);
        chk("pf_ready", 32'(req_ready_o), 32'd1);
        sbq.push_back(exp_t'{32'd50, 1'b0, 5'd25});
        push(3'd4, 2'd0, 32'd0, 8'h00, 1'b0, 5'd25);
        collect("pf_check", lat);

        // asynchronous reset during ISSUE
        p0 = pulses;
        push(3'd0, 2'd0, 32'd100, 8'h10, 1'b0, 5'd26);
        @(posedge clk_i); #1;
        chk("rr_issue", 32'(vcsr_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rr_pulse_off", 32'(vcsr_valid_o), 32'd0);
        chk("rr_rsp_off", 32'(rsp_valid_o), 32'd0);
        chk("rr_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        quiet("rr_quiet", 6);
        chk("rr_no_pulse", 32'(pulses - p0), 32'd0);
        sbq.push_back(exp_t'{32'd0, 1'b0, 5'd27});
        push(3'd4, 2'd1, 32'd0, 8'h00, 1'b0, 5'd27);
        collect("rr_vl", lat);
        sbq.push_back(exp_t'{32'd64, 1'b0, 5'd28});
        push(3'd4, 2'd3, 32'd0, 8'h00, 1'b0, 5'd28);
        collect("rr_vlenb", lat);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
